// File: rtl/sim_end_checker_pkg.sv
// sim_check_pkg: shared states, end-mode constants and packed-field helper for sim_end_checker
package sim_check_pkg;
  typedef enum logic [1:0] {S_RUN, S_CHECK, S_DONE} state_t;
  localparam int END_PC_MATCH = 0;
  localparam int END_SELF_LOOP = 1;
  function automatic logic [63:0] field(input logic [1023:0] vec, input int w, input int i);
    return 64'(vec >> (i * w)) & ((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/sim_end_checker_end_detect.sv
// end_detect: flags program completion from the core PC (fixed end PC or branch-to-self)
module end_detect
  import sim_check_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int END_MODE = END_PC_MATCH,
  parameter logic [PC_W-1:0] END_PC = PC_W'(32'h48)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pc,
  output logic            done_pulse
);
  logic [PC_W-1:0] prev_q;
  logic            started_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prev_q    <= '0;
      started_q <= 1'b0;
    end else begin
      prev_q    <= pc;
      started_q <= 1'b1;
    end
  // started_q masks the reset value of prev_q matching a pc of 0
  assign done_pulse = (END_MODE == END_SELF_LOOP) ? (started_q && pc == prev_q) : (pc == END_PC);
endmodule

// File: rtl/sim_end_checker.sv
// sim_end_checker: detects end of a core run, halts it, then compares data-memory words against expectations
module sim_end_checker
  import sim_check_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 6,
  parameter int NUM_CHECKS = 4,
  parameter int END_MODE = END_PC_MATCH,
  parameter logic [PC_W-1:0] END_PC = PC_W'(32'h48),
  parameter int TIMEOUT = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [PC_W-1:0]              pc,
  input  logic [NUM_CHECKS*MEM_AW-1:0] chk_addr,
  input  logic [NUM_CHECKS*DATA_W-1:0] chk_data,
  output logic [MEM_AW-1:0]            rd_addr,
  input  logic [DATA_W-1:0]            rd_data,
  output logic                         halt,
  output logic                         done,
  output logic                         pass,
  output logic                         timed_out,
  output logic [3:0]                   fail_idx,
  output logic [DATA_W-1:0]            fail_data,
  output logic [31:0]                  cycles
);
  state_t             state_q;
  logic [3:0]         idx_q;
  logic [31:0]        cycles_q;
  logic               done_q, pass_q, timed_out_q;
  logic [3:0]         fail_idx_q;
  logic [DATA_W-1:0]  fail_data_q;
  logic               done_pulse;
  logic [1023:0]      addr_vec, data_vec;
  logic [DATA_W-1:0]  exp_data;
  logic               match, timeout_hit;
  end_detect #(.PC_W(PC_W), .END_MODE(END_MODE), .END_PC(END_PC)) u_end (
    .clk(clk), .reset(reset), .pc(pc), .done_pulse(done_pulse)
  );
  assign addr_vec    = 1024'(chk_addr);
  assign data_vec    = 1024'(chk_data);
  assign exp_data    = DATA_W'(field(data_vec, DATA_W, int'(idx_q)));
  assign match       = rd_data == exp_data;
  assign timeout_hit = cycles_q == 32'(TIMEOUT - 2);
  assign rd_addr     = (state_q == S_CHECK) ? MEM_AW'(field(addr_vec, MEM_AW, int'(idx_q))) : '0;
  assign halt        = state_q != S_RUN;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timed_out   = timed_out_q;
  assign fail_idx    = fail_idx_q;
  assign fail_data   = fail_data_q;
  assign cycles      = cycles_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= S_RUN;
      idx_q       <= '0;
      cycles_q    <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timed_out_q <= 1'b0;
      fail_idx_q  <= '0;
      fail_data_q <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          cycles_q <= cycles_q + 32'(~&cycles_q);
          if (done_pulse) state_q <= S_CHECK;
          else if (timeout_hit) begin
            state_q     <= S_DONE;
            timed_out_q <= 1'b1;
            done_q      <= 1'b1;
          end
        end
        S_CHECK: begin
          if (!match) begin
            fail_idx_q  <= idx_q;
            fail_data_q <= rd_data;
            state_q     <= S_DONE;
            done_q      <= 1'b1;
          end else if (idx_q == 4'(NUM_CHECKS - 1)) begin
            pass_q  <= 1'b1;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else idx_q <= idx_q + 4'd1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_sim_end_checker.sv
// tb_sim_end_checker: directed scoreboard bench for sim_end_checker in end-PC, self-loop and timeout configurations
module tb_sim_end_checker;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] ram [64];
  logic [31:0] pc0, pc1, pc2;
  logic [23:0] ca0; logic [127:0] cd0;
  logic [11:0] ca1; logic [63:0] cd1;
  logic [5:0] ca2; logic [31:0] cd2;
  logic [5:0] ra0, ra1, ra2;
  logic halt0, done0, pass0, tmo0, halt1, done1, pass1, tmo1, halt2, done2, pass2, tmo2;
  logic [3:0] fi0, fi1, fi2;
  logic [31:0] fd0, fd1, fd2, cy0, cy1, cy2;
  sim_end_checker #(.NUM_CHECKS(4), .END_MODE(0), .TIMEOUT(4096)) u0 (
    .clk(clk), .reset(reset), .pc(pc0), .chk_addr(ca0), .chk_data(cd0), .rd_addr(ra0),
    .rd_data(ram[ra0]), .halt(halt0), .done(done0), .pass(pass0), .timed_out(tmo0),
    .fail_idx(fi0), .fail_data(fd0), .cycles(cy0));
  sim_end_checker #(.NUM_CHECKS(2), .END_MODE(1), .TIMEOUT(4096)) u1 (
    .clk(clk), .reset(reset), .pc(pc1), .chk_addr(ca1), .chk_data(cd1), .rd_addr(ra1),
    .rd_data(ram[ra1]), .halt(halt1), .done(done1), .pass(pass1), .timed_out(tmo1),
    .fail_idx(fi1), .fail_data(fd1), .cycles(cy1));
  sim_end_checker #(.NUM_CHECKS(1), .END_MODE(0), .TIMEOUT(16)) u2 (
    .clk(clk), .reset(reset), .pc(pc2), .chk_addr(ca2), .chk_data(cd2), .rd_addr(ra2),
    .rd_data(ram[ra2]), .halt(halt2), .done(done2), .pass(pass2), .timed_out(tmo2),
    .fail_idx(fi2), .fail_data(fd2), .cycles(cy2));
  typedef struct {
    string       tag;
    logic        pass;
    logic        tmo;
    logic [3:0]  fidx;
    logic [31:0] fdata;
    logic [31:0] cyc;
  } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic pop_cmp(input logic d, input logic p, input logic t, input logic [3:0] fi,
                         input logic [31:0] fd, input logic [31:0] cy);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".done"}, 32'(d), 32'd1);
      chk({e.tag, ".pass"}, 32'(p), 32'(e.pass));
      chk({e.tag, ".timed_out"}, 32'(t), 32'(e.tmo));
      chk({e.tag, ".fail_idx"}, 32'(fi), 32'(e.fidx));
      chk({e.tag, ".fail_data"}, fd, e.fdata);
      chk({e.tag, ".cycles"}, cy, e.cyc);
    end
  endtask
  task automatic run_pc0();
    for (int i = 0; i < 19; i++) begin
      pc0 = 32'(4 * i);
      @(negedge clk);
    end
  endtask
  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'(i * 3);
    ram[21] = 32'd7;
    pc0 = '0; pc1 = '0; pc2 = '0;
    ca0 = {6'd21, 6'd21, 6'd21, 6'd21};
    cd0 = {4{32'd7}};
    ca1 = {6'd6, 6'd5};
    cd1 = {32'd18, 32'd15};
    ca2 = 6'd21;
    cd2 = 32'd7;
    #12;
    chk("rst.done", 32'(done0), 32'd0);
    chk("rst.pass", 32'(pass0), 32'd0);
    chk("rst.halt", 32'(halt0), 32'd0);
    chk("rst.cycles", cy0, 32'd0);
    chk("rst.rd_addr", 32'(ra0), 32'd0);
    chk("rst.fail_data", fd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    // duplicate addresses: every check reads RAM[21]=7
    sb.push_back('{"pass_dup", 1'b1, 1'b0, 4'd0, 32'd0, 32'd19});
    run_pc0();
    chk("t1.halt_in_check", 32'(halt0), 32'd1);
    chk("t1.rd_addr", 32'(ra0), 32'd21);
    pc0 = '0;
    step(3);
    chk("t1.done_early", 32'(done0), 32'd0);
    step(1);
    pop_cmp(done0, pass0, tmo0, fi0, fd0, cy0);
    pc0 = 32'h48;
    step(3);
    chk("t1.frozen_cycles", cy0, 32'd19);
    chk("t1.frozen_done", 32'(done0), 32'd1);
    chk("t1.done_halt", 32'(halt0), 32'd1);
    chk("t1.rd_addr_done", 32'(ra0), 32'd0);
    ram[21] = 32'd6;
    do_reset();
    sb.push_back('{"fail_first", 1'b0, 1'b0, 4'd0, 32'd6, 32'd19});
    run_pc0();
    chk("t2.done_early", 32'(done0), 32'd0);
    step(1);
    pop_cmp(done0, pass0, tmo0, fi0, fd0, cy0);
    ram[21] = 32'd7;
    ram[23] = 32'd0;
    ca0 = {6'd23, 6'd22, 6'd21, 6'd20};
    cd0 = {32'hFF, 32'd66, 32'd7, 32'd60};
    do_reset();
    sb.push_back('{"fail_last", 1'b0, 1'b0, 4'd3, 32'd0, 32'd19});
    run_pc0();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3.halt%0d", k), 32'(halt0), 32'd1);
      chk($sformatf("t3.notdone%0d", k), 32'(done0), 32'd0);
      step(1);
    end
    pop_cmp(done0, pass0, tmo0, fi0, fd0, cy0);
    cd0 = {32'd0, 32'd66, 32'd7, 32'd60};
    do_reset();
    run_pc0();
    step(2);
    chk("t4.rd_addr_idx2", 32'(ra0), 32'd22);
    #2 reset = 1'b1;
    #1;
    chk("t4.async_halt", 32'(halt0), 32'd0);
    chk("t4.async_rd_addr", 32'(ra0), 32'd0);
    chk("t4.async_cycles", cy0, 32'd0);
    chk("t4.async_done", 32'(done0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.push_back('{"rerun_pass", 1'b1, 1'b0, 4'd0, 32'd0, 32'd19});
    run_pc0();
    step(3);
    chk("t4.done_early", 32'(done0), 32'd0);
    step(1);
    pop_cmp(done0, pass0, tmo0, fi0, fd0, cy0);
    do_reset();
    sb.push_back('{"self_loop", 1'b1, 1'b0, 4'd0, 32'd0, 32'd4});
    pc1 = 32'd0;
    step(1);
    chk("t5.pc0_no_trigger", 32'(halt1), 32'd0);
    pc1 = 32'd4;
    step(1);
    pc1 = 32'd8;
    step(1);
    chk("t5.first8_no_trigger", 32'(halt1), 32'd0);
    step(1);
    chk("t5.second8_trigger", 32'(halt1), 32'd1);
    chk("t5.done_early", 32'(done1), 32'd0);
    step(1);
    chk("t5.done_early2", 32'(done1), 32'd0);
    step(1);
    pop_cmp(done1, pass1, tmo1, fi1, fd1, cy1);
    do_reset();
    sb.push_back('{"timeout", 1'b0, 1'b1, 4'd0, 32'd0, 32'd15});
    step(14);
    chk("t6.done_early", 32'(done2), 32'd0);
    chk("t6.tmo_early", 32'(tmo2), 32'd0);
    step(1);
    pop_cmp(done2, pass2, tmo2, fi2, fd2, cy2);
    chk("t6.halt", 32'(halt2), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
